// File: rtl/hilo_div_pkg.sv
// Shared state encodings, handshake constants and sign helpers for the HI/LO divider.
package hilo_div_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByzero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [5:0] DivSteps = 6'd32;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // -2^31 maps to 0x80000000, which is its correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division step: shift the working register left and trial-subtract the divisor.
module hilo_div_step
   import hilo_div_pkg::*;
(
   input  logic [64:0] work_i,
   input  logic [31:0] divisor_i,
   output logic [64:0] work_o
);

   logic [65:0] shifted;
   logic [33:0] trial;

   // One spare bit above the 33-bit remainder keeps the borrow visible for any shifted value.
   always_comb begin
      shifted = {work_i, 1'b0};
      trial   = shifted[65:32] - {2'b00, divisor_i};
      if (!trial[33]) begin
         work_o = {trial[32:0], shifted[31:1], 1'b1};
      end else begin
         work_o = shifted[64:0];
      end
   end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle 32-bit DIV/DIVU unit returning {remainder, quotient} for the HI/LO write path.
module hilo_div
   import hilo_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stall_o
);

   div_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [64:0] work_q;
   logic [64:0] work_next;
   logic [31:0] divisor_q;
   logic        signed_q;
   logic        sign_a_q;
   logic        sign_b_q;
   logic        accept;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   hilo_div_step u_step (
      .work_i    (work_q),
      .divisor_i (divisor_q),
      .work_o    (work_next)
   );

   assign accept = (start_i == DivStart) && !annul_i;

   always_comb begin
      quo_fix = work_q[31:0];
      rem_fix = work_q[63:32];
      if (signed_q && (sign_a_q ^ sign_b_q)) quo_fix = neg32(work_q[31:0]);
      if (signed_q && sign_a_q)              rem_fix = neg32(work_q[63:32]);
   end

   assign stall_o = ((state_q == DivFree) && accept) || (state_q == DivByzero) ||
                    (state_q == DivOn);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         signed_q  <= 1'b0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         ready_o <= DivResultNotReady;
         unique case (state_q)
            DivFree: begin
               if (accept) begin
                  if (opdata2_i == 32'd0) begin
                     state_q <= DivByzero;
                  end else begin
                     state_q   <= DivOn;
                     cnt_q     <= '0;
                     signed_q  <= signed_i;
                     sign_a_q  <= signed_i & opdata1_i[31];
                     sign_b_q  <= signed_i & opdata2_i[31];
                     work_q    <= {33'd0, signed_i ? abs32(opdata1_i) : opdata1_i};
                     divisor_q <= signed_i ? abs32(opdata2_i) : opdata2_i;
                  end
               end
            end
            DivByzero: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  state_q  <= DivEnd;
                  result_o <= '0;
                  ready_o  <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else if (cnt_q != DivSteps) begin
                  work_q <= work_next;
                  cnt_q  <= cnt_q + 6'd1;
               end else begin
                  // All 32 steps done; this cycle applies the sign fix-up and publishes.
                  state_q  <= DivEnd;
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= DivResultReady;
               end
            end
            DivEnd: begin
               state_q <= DivFree;
               cnt_q   <= '0;
            end
            default: state_q <= DivFree;
         endcase
      end
   end

endmodule

// File: doc/hilo_div.md
# hilo_div

Multi-cycle 32-bit divider that executes the DIV/DIVU commands the main decoder issues with HI/LO write enabled. It sits beside the ALU in the execute stage, accepts a start request with two operands, and stalls the pipeline while it works. It returns {remainder, quotient} for the HI/LO register write.

## Interface
- No parameters; the width is fixed at 32 bits.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  division request; sampled only in FREE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- annul_i  in  1  exception/flush; aborts any division in progress.
- result_o  out  64  {HI = remainder, LO = quotient}; registered.
- ready_o  out  1  result valid; registered.
- stall_o  out  1  pipeline stall request; combinational.

## Operation
- States: FREE, BYZERO, ON, END.
- FREE:
  - Condition for accepting: start_i=1 and annul_i=0.
  - If opdata2_i=0, go to BYZERO.
  - Otherwise latch the operands and go to ON with cnt=0.
  - When signed_i=1, latch absolute values, and record the two operand signs and signed_i.
- BYZERO: result=0, go to END.
- ON, one restoring step per cycle:
  - Working register is 65 bits: {rem[32:0], quo[31:0]}.
  - Shift left by 1.
  - Trial-subtract the divisor (33-bit) from rem.
  - If the difference is non-negative, rem takes the difference and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - cnt increments each step. After the step with cnt=31, go to END.
- Leaving ON (signed mode):
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend was negative.
  - Load result_o.
- END: ready_o=1 for exactly this one cycle, then go to FREE.
- result_o holds its value until the next result is loaded. It is not cleared on leaving END.
- annul_i=1 in ON or BYZERO: go to FREE next edge. ready_o stays 0 and result_o is unchanged.
- annul_i in END has no effect.
- Overflow case: signed -2^31 / -1 gives quotient 0x80000000 and remainder 0, wrapped with no trap.
- Unsigned mode uses the operands raw; no sign fix-up.
- stall_o = (FREE & start_i & !annul_i) | BYZERO | ON. It is 0 in END.
- The pipeline advances in the END cycle and must deassert start_i or present a new instruction. A start_i still high in FREE begins a new division.

## Timing
- Reset values: state=FREE, cnt=0, result_o=0, ready_o=0, stall_o=0 (with start_i low).
- Normal latency: start accepted at edge E0, ON during E0..E0+32, END after edge E0+33. ready_o and result_o are valid in that cycle: 34 cycles from request to result.
- Divide-by-zero: BYZERO after E0, END after E0+1, ready_o high in the cycle after E0+1.
- Reset asserted mid-division: immediate return to FREE with all outputs at their reset values.
- start_i is ignored in ON, BYZERO and END. The operand inputs are don't-care after the acceptance edge.

## Structure
- defines.vh:
  - State encodings: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2 bits).
  - DIV_RESULT_READY / DIV_RESULT_NOT_READY.
  - DIV_START / DIV_STOP.
- One sub-module, div_step: combinational 33-bit trial subtract and shift. Inputs are the working register and the divisor; output is the next working register.
- The FSM, counter and sign fix-up stay in hilo_div. The result is consumed by the HI/LO write path under hilowrite.

## Test plan
- DIVU 100/7, start held until ready:
  - ready_o high exactly 34 cycles after acceptance; result_o = {0x00000002, 0x0000000E}.
  - stall_o high for 34 cycles, then 0 in END.
- DIV -7/2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 7/-2: quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000/0xFFFFFFFF: result_o = {0x00000000, 0x80000000}. DIVU of the same operands gives {0x80000000, 0x00000000}.
- Divisor 0: ready_o high 2 cycles after acceptance; result_o = 0.
- annul_i pulsed 10 cycles into ON:
  - FREE next cycle, ready_o never asserts, result_o keeps its prior value.
  - A following DIVU 9/3 gives {0, 3}.
- rst asserted asynchronously mid-ON:
  - Outputs zero without waiting for a clock edge.
  - After release, a new division completes in 34 cycles.
